// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Provides the access-size encoding, the controller FSM states,
// the doubleword geometry and a misalignment helper.
package lsu_pkg;

   localparam int unsigned DWORD_BYTES = 8;
   localparam int unsigned DWORD_W     = 64;
   localparam int unsigned DW_SHIFT    = $clog2(DWORD_BYTES);

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_D = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      RCAP = 3'd2,
      WR   = 3'd3,
      RESP = 3'd4
   } state_e;

   // True when the byte offset within the doubleword is not a multiple of the size.
   function automatic logic misaligned(input size_e sz, input logic [2:0] offs);
      logic bad;
      case (sz)
         SZ_H:    bad = offs[0];
         SZ_W:    bad = |offs[1:0];
         SZ_D:    bad = |offs;
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane handling between a memory doubleword and a right-aligned scalar.
// Ports:
//   word   - doubleword read from memory
//   wdata  - right-aligned store data
//   offs   - byte offset of the access inside the doubleword
//   size   - access size
//   uns    - zero-extend (1) or sign-extend (0) loads
//   load_c  - extracted and extended load value
//   merge_c - word with the store lane replaced by wdata
module lsu_align
   import lsu_pkg::*;
(
   input  logic [DWORD_W-1:0] word,
   input  logic [DWORD_W-1:0] wdata,
   input  logic [2:0]         offs,
   input  size_e              size,
   input  logic               uns,
   output logic [DWORD_W-1:0] load_c,
   output logic [DWORD_W-1:0] merge_c
);

   logic [5:0]         shamt;
   logic [DWORD_W-1:0] lane;
   logic [DWORD_W-1:0] mask;
   logic [DWORD_W-1:0] mask_s;

   assign shamt = {offs, 3'b000};
   assign lane  = word >> shamt;

   // Extract the selected lane and extend it to a full doubleword.
   always_comb begin
      load_c = lane;
      case (size)
         SZ_B: load_c = uns ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
         SZ_H: load_c = uns ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
         SZ_W: load_c = uns ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
         default: load_c = lane;
      endcase
   end

   // Replace only the addressed lane of the sampled word.
   always_comb begin
      mask = '1;
      case (size)
         SZ_B:    mask = 64'h0000_0000_0000_00FF;
         SZ_H:    mask = 64'h0000_0000_0000_FFFF;
         SZ_W:    mask = 64'h0000_0000_FFFF_FFFF;
         default: mask = '1;
      endcase
   end

   assign mask_s  = mask << shamt;
   assign merge_c = (word & ~mask_s) | ((wdata << shamt) & mask_s);

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller in front of a 64-bit synchronous data memory.
// Sub-doubleword stores are done as read-modify-write; misaligned
// accesses are answered with resp_err and never reach memory.
// Ports:
//   req_*  - request handshake (addr, store data, size, signedness)
//   resp_* - response handshake (load data, misalignment flag)
//   mem_*  - doubleword-indexed memory port; read data returns one cycle after mem_r
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [DATA_W-1:0] mem_datain,
   output logic              mem_w,
   output logic              mem_r,
   input  logic [DATA_W-1:0] mem_dataout
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   size_e             size_q, size_d;
   logic              we_q, we_d;
   logic              uns_q, uns_d;

   logic              req_ready_d, resp_valid_d, resp_err_d, mem_w_d, mem_r_d;
   logic [DATA_W-1:0] resp_rdata_d, mem_datain_d;
   logic [ADDR_W-1:0] mem_adr_d;

   logic [DATA_W-1:0] load_c, merge_c;

   lsu_align u_align (
      .word    (mem_dataout),
      .wdata   (wdata_q),
      .offs    (addr_q[2:0]),
      .size    (size_q),
      .uns     (uns_q),
      .load_c  (load_c),
      .merge_c (merge_c)
   );

   // State, latched request and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         size_q     <= SZ_B;
         we_q       <= 1'b0;
         uns_q      <= 1'b0;
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         mem_adr    <= '0;
         mem_datain <= '0;
         mem_w      <= 1'b0;
         mem_r      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         size_q     <= size_d;
         we_q       <= we_d;
         uns_q      <= uns_d;
         req_ready  <= req_ready_d;
         resp_valid <= resp_valid_d;
         resp_rdata <= resp_rdata_d;
         resp_err   <= resp_err_d;
         mem_adr    <= mem_adr_d;
         mem_datain <= mem_datain_d;
         mem_w      <= mem_w_d;
         mem_r      <= mem_r_d;
      end
   end

   // Next state; outputs are computed for the next state so they line up with it.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      size_d       = size_q;
      we_d         = we_q;
      uns_d        = uns_q;
      resp_rdata_d = resp_rdata;
      resp_err_d   = resp_err;
      mem_datain_d = mem_datain;

      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               addr_d       = req_addr;
               wdata_d      = req_wdata;
               size_d       = size_e'(req_size);
               we_d         = req_we;
               uns_d        = req_unsigned;
               resp_rdata_d = '0;
               resp_err_d   = 1'b0;
               if (misaligned(size_e'(req_size), req_addr[2:0])) begin
                  resp_err_d = 1'b1;
                  state_d    = RESP;
               end else if (req_we && (size_e'(req_size) == SZ_D)) begin
                  mem_datain_d = req_wdata;
                  state_d      = WR;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD:   state_d = RCAP;
         RCAP: begin
            if (we_q) begin
               mem_datain_d = merge_c;
               state_d      = WR;
            end else begin
               resp_rdata_d = load_c;
               state_d      = RESP;
            end
         end
         WR:   state_d = RESP;
         RESP: if (resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      req_ready_d  = (state_d == IDLE);
      resp_valid_d = (state_d == RESP);
      mem_r_d      = (state_d == RD);
      mem_w_d      = (state_d == WR);
      mem_adr_d    = (mem_r_d || mem_w_d) ? (addr_d >> DW_SHIFT) : '0;
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl with a small synchronous memory model.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [63:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic        resp_valid, resp_ready, resp_err;
   logic [63:0] resp_rdata;
   logic [63:0] mem_adr, mem_datain, mem_dataout;
   logic        mem_w, mem_r;

   int checks = 0;
   int fails  = 0;

   logic [63:0] mem [16];
   int          nr_cnt = 0;
   int          nw_cnt = 0;
   logic [63:0] last_wdata = '0;
   logic [63:0] last_wadr  = '0;

   int          lat, nr, nw;
   logic [63:0] rd;
   logic        er;
   int          w0;

   always #5 clk = ~clk;

   lsu_ctrl #(.ADDR_W(64), .DATA_W(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
      .req_unsigned(req_unsigned),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_adr(mem_adr), .mem_datain(mem_datain), .mem_w(mem_w), .mem_r(mem_r),
      .mem_dataout(mem_dataout)
   );

   // Memory: read data appears the cycle after mem_r.
   always @(posedge clk) begin
      if (mem_r) begin
         mem_dataout <= mem[mem_adr[3:0]];
         nr_cnt      <= nr_cnt + 1;
      end
      if (mem_w) begin
         mem[mem_adr[3:0]] <= mem_datain;
         nw_cnt     <= nw_cnt + 1;
         last_wdata <= mem_datain;
         last_wadr  <= mem_adr;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outs(input string tag);
      chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
      chk({tag, "_resp_rdata"}, resp_rdata, 64'd0);
      chk({tag, "_resp_err"},   64'(resp_err), 64'd0);
      chk({tag, "_mem_adr"},    mem_adr, 64'd0);
      chk({tag, "_mem_datain"}, mem_datain, 64'd0);
      chk({tag, "_mem_w"},      64'(mem_w), 64'd0);
      chk({tag, "_mem_r"},      64'(mem_r), 64'd0);
   endtask

   // One full transaction; latency counted in cycles after the handshake cycle.
   task automatic txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [1:0] size, input logic uns, input int hold,
                      output int l, output logic [63:0] rdata, output logic err,
                      output int r_n, output int w_n);
      int          r0, wr0, budget;
      logic [63:0] snap;
      r0  = nr_cnt;
      wr0 = nw_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      req_size = size; req_unsigned = uns;
      budget = 0;
      while (!req_ready && budget < 20) begin @(negedge clk); budget++; end
      if (!req_ready) chk("req_ready_wait", 64'(req_ready), 64'd1);
      @(negedge clk);
      req_valid = 1'b0;
      l = 1;
      while (!resp_valid && l < 20) begin @(negedge clk); l++; end
      snap = resp_rdata;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_resp_valid", 64'(resp_valid), 64'd1);
         chk("hold_resp_rdata", resp_rdata, snap);
         chk("hold_req_ready",  64'(req_ready), 64'd0);
      end
      rdata = resp_rdata;
      err   = resp_err;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      r_n = nr_cnt - r0;
      w_n = nw_cnt - wr0;
      chk("after_resp_valid", 64'(resp_valid), 64'd0);
      chk("after_req_ready",  64'(req_ready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      req_size = 2'b00; req_unsigned = 1'b0; resp_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_idle_outs("rst");
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_req_ready", 64'(req_ready), 64'd1);

      // dword store
      txn(1'b1, 64'h50, 64'h0000_ABCD_EFFE_DCBA, 2'b11, 1'b0, 0, lat, rd, er, nr, nw);
      chk("sd_lat", 64'(lat), 64'd2);
      chk("sd_err", 64'(er), 64'd0);
      chk("sd_nw", 64'(nw), 64'd1);
      chk("sd_nr", 64'(nr), 64'd0);
      chk("sd_adr", last_wadr, 64'd10);
      chk("sd_data", last_wdata, 64'h0000_ABCD_EFFE_DCBA);

      // dword load
      txn(1'b0, 64'h50, 64'h0, 2'b11, 1'b0, 0, lat, rd, er, nr, nw);
      chk("ld_lat", 64'(lat), 64'd3);
      chk("ld_data", rd, 64'h0000_ABCD_EFFE_DCBA);
      chk("ld_nr", 64'(nr), 64'd1);
      chk("ld_nw", 64'(nw), 64'd0);

      // byte loads from lane 2 holding 0x80
      txn(1'b1, 64'h50, 64'h0000_0000_0080_0000, 2'b11, 1'b0, 0, lat, rd, er, nr, nw);
      txn(1'b0, 64'h52, 64'h0, 2'b00, 1'b0, 0, lat, rd, er, nr, nw);
      chk("lb_signed", rd, 64'hFFFF_FFFF_FFFF_FF80);
      chk("lb_lat", 64'(lat), 64'd3);
      txn(1'b0, 64'h52, 64'h0, 2'b00, 1'b1, 0, lat, rd, er, nr, nw);
      chk("lbu", rd, 64'h0000_0000_0000_0080);

      // half store read-modify-write over all-ones
      txn(1'b1, 64'h50, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0, 0, lat, rd, er, nr, nw);
      txn(1'b1, 64'h54, 64'hDEAD_BEEF_0000_1234, 2'b01, 1'b0, 0, lat, rd, er, nr, nw);
      chk("sh_lat", 64'(lat), 64'd4);
      chk("sh_nr", 64'(nr), 64'd1);
      chk("sh_nw", 64'(nw), 64'd1);
      chk("sh_data", last_wdata, 64'hFFFF_1234_FFFF_FFFF);
      chk("sh_adr", last_wadr, 64'd10);
      chk("sh_rdata", rd, 64'd0);

      // misaligned word load
      txn(1'b0, 64'h52, 64'h0, 2'b10, 1'b0, 0, lat, rd, er, nr, nw);
      chk("mis_lat", 64'(lat), 64'd1);
      chk("mis_err", 64'(er), 64'd1);
      chk("mis_rdata", rd, 64'd0);
      chk("mis_nr", 64'(nr), 64'd0);
      chk("mis_nw", 64'(nw), 64'd0);

      // signed word load with response back-pressure
      txn(1'b0, 64'h54, 64'h0, 2'b10, 1'b0, 5, lat, rd, er, nr, nw);
      chk("lw_data", rd, 64'hFFFF_FFFF_FFFF_1234);
      chk("lw_err", 64'(er), 64'd0);

      // reset while in WR of a byte RMW
      w0 = nw_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h50; req_wdata = 64'h55;
      req_size = 2'b00; req_unsigned = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rmw_in_wr", 64'(mem_w), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check_idle_outs("rmw_rst");
      chk("rmw_rst_req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
      chk("rmw_no_write", 64'(nw_cnt - w0), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rmw_req_ready", 64'(req_ready), 64'd1);
      txn(1'b0, 64'h50, 64'h0, 2'b11, 1'b0, 0, lat, rd, er, nr, nw);
      chk("rmw_mem_kept", rd, 64'hFFFF_1234_FFFF_FFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, meaning request/memory address width.
REQ-002 SHALL have parameter DATA_W, default 64, meaning data width; only 64 is supported.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-009 SHALL have port req_wdata  input  DATA_W  store data, right-aligned.
REQ-010 SHALL have port req_size  input  2  access size: 00 byte, 01 half, 10 word, 11 dword.
REQ-011 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-012 SHALL have port resp_valid  output  1  response present.
REQ-013 SHALL have port resp_ready  input  1  response consumed when high with resp_valid.
REQ-014 SHALL have port resp_rdata  output  DATA_W  extended load data; 0 for stores and errors.
REQ-015 SHALL have port resp_err  output  1  misaligned access flag.
REQ-016 SHALL have ports mem_adr (output, ADDR_W), mem_datain (output, DATA_W), mem_w (output, 1), mem_r (output, 1), mem_dataout (input, DATA_W), connecting to the 64-bit data memory.

Function
REQ-017 SHALL implement the FSM states IDLE, RD, RCAP, WR and RESP.
REQ-018 SHALL assert req_ready only in IDLE; a handshake latches addr, wdata, size, we and unsigned.
REQ-019 SHALL go from IDLE to RESP with resp_err=1 and no memory access when req_addr is not aligned to the size (half: bit0; word: bits1:0; dword: bits2:0).
REQ-020 SHALL drive mem_adr = latched addr >> 3 (doubleword index) in RD and WR, and 0 otherwise.
REQ-021 SHALL, for loads and sub-dword stores, go IDLE->RD, assert mem_r for exactly the one RD cycle, then go to RCAP.
REQ-022 SHALL in RCAP sample mem_dataout (the memory returns data the cycle after mem_r).
REQ-023 SHALL, for loads in RCAP, extract the lane selected by addr[2:0], extend it per req_unsigned, register the result to resp_rdata, and go to RESP.
REQ-024 SHALL, for sub-dword stores in RCAP, merge the wdata lane into the sampled word and go to WR (read-modify-write).
REQ-025 SHALL, for dword stores, go IDLE->WR directly with mem_datain = wdata.
REQ-026 SHALL in WR assert mem_w for exactly one cycle with mem_datain stable, then go to RESP.
REQ-027 SHALL hold resp_valid high in RESP, with resp_rdata and resp_err stable, until resp_ready, then return to IDLE; no back-to-back acceptance occurs in the same cycle.
REQ-028 SHALL deassert mem_w and mem_r in all states other than WR and RD respectively; they are never high together.
REQ-029 SHALL give latency from handshake edge to resp_valid of: dword store 2 cycles, load 3, sub-dword store 4, misaligned 1.

Reset
REQ-030 SHALL on rst_n low, immediately and regardless of state, enter IDLE and clear req_ready, resp_valid, resp_rdata, resp_err, mem_adr, mem_datain, mem_w and mem_r to 0.
REQ-031 SHALL, on reset mid-RMW, abort the operation with no write issued; req_ready rises the first cycle after rst_n deasserts.

Structure
REQ-032 SHALL place the size encoding enum, the FSM state enum, and the DWORD_BYTES=8 constant in shared package lsu_pkg.
REQ-033 SHALL put lane extract/extend and lane merge in combinational sub-module lsu_align.

Verification
REQ-034 SHALL cover: dword store addr 0x50, data 0xABCDEFFEDCBA -> mem_w one cycle with mem_adr 10; resp_valid 2 cycles after handshake, resp_err 0.
REQ-035 SHALL cover: dword load addr 0x50 after the above -> mem_r one cycle; resp_rdata 0x0000ABCDEFFEDCBA, 3 cycles latency.
REQ-036 SHALL cover: byte load addr 0x52 signed from memory word 0x...80 at lane2 -> resp_rdata 0xFFFFFFFFFFFFFF80; unsigned -> 0x80.
REQ-037 SHALL cover: half store 0x1234 at addr 0x54 over word 0xFFFFFFFFFFFFFFFF -> mem_datain 0xFFFF1234FFFFFFFF, one mem_r then one mem_w.
REQ-038 SHALL cover: word load addr 0x52 -> resp_err 1, resp_rdata 0, no mem_r or mem_w, resp_valid 1 cycle later.
REQ-039 SHALL cover: resp_ready held low 5 cycles -> resp_valid and resp_rdata stable, req_ready 0; rst_n pulse during WR of an RMW -> no mem_w, all outputs 0.
